// File: rtl/aluio_pkg.sv
// Shared constants for the demux3_reg slice: data width, slot count, select width.
package aluio_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned SLOT_CNT = 8;
   localparam int unsigned SEL_W    = 3;

endpackage

// File: rtl/demux3_reg_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives the per-slot write strobes of demux3_reg.
module dec3to8
   import aluio_pkg::*;
(
   input  logic [SEL_W-1:0]    i_sel,
   input  logic                i_en,
   output logic [SLOT_CNT-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/demux3_reg.sv
// Registered 1-to-8 demultiplexer with per-slot full flags and consumer acks.
// Optional macro DEMUX3_REG_PASSTHRU_ACK_EN: a same-cycle ack frees the slot for the incoming write.
module demux3_reg
   import aluio_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    din,
   input  logic [SEL_W-1:0]    dest,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [WIDTH-1:0]    o0,
   output logic [WIDTH-1:0]    o1,
   output logic [WIDTH-1:0]    o2,
   output logic [WIDTH-1:0]    o3,
   output logic [WIDTH-1:0]    o4,
   output logic [WIDTH-1:0]    o5,
   output logic [WIDTH-1:0]    o6,
   output logic [WIDTH-1:0]    o7,
   output logic [SLOT_CNT-1:0] full,
   input  logic [SLOT_CNT-1:0] ack,
   output logic                busy
);

   logic [WIDTH-1:0]    r_data [SLOT_CNT];
   logic [SLOT_CNT-1:0] r_full;
   logic [SLOT_CNT-1:0] w_we;
   logic                w_ready;
   logic                w_accept;

`ifdef DEMUX3_REG_PASSTHRU_ACK_EN
   assign w_ready = ~r_full[dest] | ack[dest];
`else
   assign w_ready = ~r_full[dest];
`endif

   assign w_accept = in_valid & w_ready;

   dec3to8 u_dec (
      .i_sel    (dest),
      .i_en     (w_accept),
      .o_onehot (w_we)
   );

   // A write to a slot wins over its ack, so full stays set when both hit together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= '0;
         for (int unsigned k = 0; k < SLOT_CNT; k++) r_data[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < SLOT_CNT; k++) begin
            if (w_we[k]) r_data[k] <= din;
            r_full[k] <= w_we[k] | (r_full[k] & ~ack[k]);
         end
      end
   end

   assign in_ready = w_ready;
   assign full     = r_full;
   assign busy     = |r_full;
   assign o0       = r_data[0];
   assign o1       = r_data[1];
   assign o2       = r_data[2];
   assign o3       = r_data[3];
   assign o4       = r_data[4];
   assign o5       = r_data[5];
   assign o6       = r_data[6];
   assign o7       = r_data[7];

endmodule

// File: tb/tb_demux3_reg.sv
// Self-checking bench for demux3_reg: directed scenarios plus randomized traffic against a slot model.
module tb_demux3_reg;
   import aluio_pkg::*;

   localparam int unsigned W = DATA_W;
`ifdef DEMUX3_REG_PASSTHRU_ACK_EN
   localparam bit PASS = 1'b1;
`else
   localparam bit PASS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, busy;
   logic [W-1:0] din;
   logic [2:0]   dest;
   logic [7:0]   full, ack;
   logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
   logic [W-1:0] dut_o [8];

   int errors = 0;
   int checks = 0;

   logic [W-1:0] m_o [8];
   logic [7:0]   m_full;
   logic         obs_ready, exp_ready;

   always #5 clk = ~clk;

   demux3_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din(din), .dest(dest), .in_valid(in_valid), .in_ready(in_ready),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
      .full(full), .ack(ack), .busy(busy)
   );

   assign dut_o[0] = o0; assign dut_o[1] = o1; assign dut_o[2] = o2; assign dut_o[3] = o3;
   assign dut_o[4] = o4; assign dut_o[5] = o5; assign dut_o[6] = o6; assign dut_o[7] = o7;

   // Drive one cycle, sample in_ready before the edge, and advance the slot model by its rules.
   task automatic drive(input logic r, input logic v, input logic [2:0] d,
                        input logic [W-1:0] x, input logic [7:0] a);
      rst = r; in_valid = v; dest = d; din = x; ack = a;
      #1;
      obs_ready = in_ready;
      exp_ready = !m_full[d] || (PASS && a[d]);
      if (r) begin
         m_full = 8'h00;
         for (int k = 0; k < 8; k++) m_o[k] = '0;
      end else begin
         m_full = m_full & ~a;
         if (v && exp_ready) begin
            m_o[d]    = x;
            m_full[d] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 3'd6, 16'hFFFF, 8'hFF);
      checks++; if (full !== 8'h00) begin errors++; $display("FAIL reset_full: got %h want 00", full); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (dut_o[k] !== '0) begin errors++; $display("FAIL reset_o%0d: got %h want 0000", k, dut_o[k]); end
      end
      rst = 1'b0; in_valid = 1'b0; ack = 8'h00;
      for (int k = 0; k < 8; k++) begin
         dest = 3'(k);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready%0d: got %b want 1", k, in_ready); end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_write();
      drive(1'b0, 1'b1, 3'd3, 16'hA5A5, 8'h00);
      checks++; if (o3 !== 16'hA5A5) begin errors++; $display("FAIL write_o3: got %h want a5a5", o3); end
      checks++; if (full !== 8'h08) begin errors++; $display("FAIL write_full: got %h want 08", full); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
      for (int k = 0; k < 8; k++) begin
         if (k != 3) begin
            checks++;
            if (dut_o[k] !== '0) begin errors++; $display("FAIL write_o%0d: got %h want 0000", k, dut_o[k]); end
         end
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b1, 3'd3, 16'h1234, 8'h00);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", obs_ready); end
      checks++; if (o3 !== 16'hA5A5) begin errors++; $display("FAIL stall_o3: got %h want a5a5", o3); end
      drive(1'b0, 1'b1, 3'd3, 16'h1234, 8'h08);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL stall_ack_ready: got %b want %b", obs_ready, exp_ready); end
      checks++; if (full !== m_full) begin errors++; $display("FAIL stall_ack_full: got %h want %h", full, m_full); end
      drive(1'b0, 1'b1, 3'd3, 16'h1234, 8'h00);
      checks++; if (o3 !== 16'h1234) begin errors++; $display("FAIL stall_land_o3: got %h want 1234", o3); end
      checks++; if (full[3] !== 1'b1) begin errors++; $display("FAIL stall_land_full3: got %b want 1", full[3]); end
      in_valid = 1'b0;
   endtask

   task automatic test_same_cycle();
      drive(1'b0, 1'b1, 3'd3, 16'h0F0F, 8'h08);
`ifdef DEMUX3_REG_PASSTHRU_ACK_EN
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b want 1", obs_ready); end
      checks++; if (o3 !== 16'h0F0F) begin errors++; $display("FAIL same_o3: got %h want 0f0f", o3); end
      checks++; if (full[3] !== 1'b1) begin errors++; $display("FAIL same_full3: got %b want 1", full[3]); end
`else
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL same_ready: got %b want 0", obs_ready); end
      checks++; if (full[3] !== 1'b0) begin errors++; $display("FAIL same_full3: got %b want 0", full[3]); end
      checks++; if (o3 !== 16'h1234) begin errors++; $display("FAIL same_hold_o3: got %h want 1234", o3); end
      drive(1'b0, 1'b1, 3'd3, 16'h0F0F, 8'h00);
      checks++; if (o3 !== 16'h0F0F) begin errors++; $display("FAIL same_late_o3: got %h want 0f0f", o3); end
      checks++; if (full[3] !== 1'b1) begin errors++; $display("FAIL same_late_full3: got %b want 1", full[3]); end
`endif
      in_valid = 1'b0;
   endtask

   task automatic test_fill_all();
      drive(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF);
      for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 3'(k), W'(k), 8'h00);
      checks++; if (full !== 8'hFF) begin errors++; $display("FAIL fill_full: got %h want ff", full); end
      drive(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF);
      checks++; if (full !== 8'h00) begin errors++; $display("FAIL drain_full: got %h want 00", full); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (dut_o[k] !== W'(k)) begin errors++; $display("FAIL drain_o%0d: got %h want %h", k, dut_o[k], W'(k)); end
      end
   endtask

   task automatic test_ack_empty_and_reset();
      drive(1'b0, 1'b0, 3'd0, 16'h0000, 8'h20);
      checks++; if (full !== 8'h00) begin errors++; $display("FAIL ackempty_full: got %h want 00", full); end
      checks++; if (o5 !== 16'h0005) begin errors++; $display("FAIL ackempty_o5: got %h want 0005", o5); end
      drive(1'b1, 1'b1, 3'd2, 16'hBEEF, 8'h00);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rstwr_ready: got %b want 1", obs_ready); end
      checks++; if (full !== 8'h00) begin errors++; $display("FAIL rstwr_full: got %h want 00", full); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (dut_o[k] !== '0) begin errors++; $display("FAIL rstwr_o%0d: got %h want 0000", k, dut_o[k]); end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic       r, v;
         logic [7:0] a;
         r = ($urandom_range(0, 39) == 0);
         v = $urandom_range(0, 1);
         a = 8'($urandom) & 8'($urandom);
         drive(r, v, 3'($urandom_range(0, 7)), W'($urandom), a);
         checks++;
         if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
         checks++;
         if (full !== m_full) begin errors++; $display("FAIL rnd_full[%0d]: got %h want %h", n, full, m_full); end
         checks++;
         if (busy !== (m_full != 8'h00)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, m_full != 8'h00); end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_o[k] !== m_o[k]) begin errors++; $display("FAIL rnd_o%0d[%0d]: got %h want %h", k, n, dut_o[k], m_o[k]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; dest = 3'd0; din = '0; ack = 8'h00;
      m_full = 8'h00;
      for (int k = 0; k < 8; k++) m_o[k] = '0;
      test_reset();
      test_write();
      test_stall();
      test_same_cycle();
      test_fill_all();
      test_ack_empty_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
